usb_tx_sched: RTL and testbench
===============================

# usb_tx_sched

Transmit-side controller for the USB device core's IN path. It buffers 8-bit ADC samples into a stream FIFO and holds one host-bound response message from a second requester. When the core services an IN transaction, it selects the source by endpoint number, sizes the packet and sequences bytes out on the core's txval/txcork/txdat/txdat_len/txpop handshake. It sits between the ADC capture logic, the command/response logic and the USB core.

## Interface
- FIFO_AW, 9: stream FIFO address width (depth 2^FIFO_AW bytes)
- MAX_PKT, 64: max IN packet size, 1..2047
- STREAM_EP, 1: endpoint number served from the stream FIFO
- RESP_EP, 2: endpoint number served from the response buffer
- RESP_DEPTH, 64: response buffer size in bytes, ≤ MAX_PKT

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous reset, active-high
- adc_valid  in  1  sample strobe, one byte per cycle
- adc_data  in  8  sample byte
- resp_valid  in  1  response byte strobe
- resp_data  in  8  response byte
- resp_last  in  1  marks final response byte
- resp_ready  out  1  response buffer accepts bytes
- txact  in  1  core is servicing an IN transaction
- endpt  in  4  endpoint of current/pending transaction
- txpop  in  1  core consumed txdat
- txval  out  1  txdat holds an unsent packet byte
- txcork  out  1  1 = nothing to send (NAK)
- txdat  out  8  current byte
- txdat_len  out  12  packet length in bytes
- ovf  out  1  sticky: sample dropped
- ovf_clr  in  1  clears ovf
- fifo_level  out  FIFO_AW+1  stream FIFO occupancy

## Operation
- Reset values: txval 0, txcork 1, txdat 0, txdat_len 0, resp_ready 1, ovf 0, fifo_level 0. State is IDLE. FIFO and response buffer are emptied.
- States: IDLE, SEND.
- IDLE, every cycle registers the following from endpt:
  - STREAM_EP: txdat_len = min(fifo_level, MAX_PKT); txcork = (len==0); txdat = FIFO head.
  - RESP_EP: if a response is complete, txdat_len = resp length and txcork 0; otherwise txdat_len 0 and txcork 1. txdat = byte 0.
  - Any other endpt: txcork 1, txdat_len 0.
- IDLE→SEND when txact=1. Endpoint, txdat_len and txcork are frozen for the packet and the sent counter is cleared. txval = (sent < txdat_len).
- In SEND, txpop with sent<len advances the source pointer and increments sent; txdat shows the next byte on the following cycle. txpop with sent==len, or outside SEND, is ignored.
- SEND→IDLE when txact=0.
- Stream FIFO:
  - adc_valid writes when not full.
  - If full, the byte is dropped and ovf is set. A write while full in the same cycle as a pop is accepted.
  - A simultaneous write and pop leaves fifo_level unchanged.
- Response buffer:
  - resp_ready=1 only while no response is held and the buffer is not being sent.
  - Bytes load on resp_valid&resp_ready. resp_last (or reaching RESP_DEPTH bytes) completes the response and drops resp_ready.
  - The response is released per Configuration, after which resp_ready returns to 1.
- ovf_clr clears ovf. A drop in the same cycle wins, so ovf stays 1.
- rst mid-packet aborts: all buffered data is discarded and outputs return to reset values.

## Timing
- txcork/txdat_len/txdat are valid 1 cycle after endpt changes in IDLE. The core holds endpt ≥1 cycle before raising txact.
- txpop→new txdat: 1 cycle. The core issues txpop no faster than every other cycle.
- fifo_level reflects a write or pop 1 cycle later.
- Packet length never changes while txact=1.

## Configuration
- USB_TX_RETRY_EN defined:
  - Stream read pointer commits only when txact falls with sent==len. If txact falls with sent<len, the pointer rewinds to packet start and the bytes are resent on the next IN.
  - Full/level use the committed pointer.
  - The response is released only on complete send; otherwise it is retained.
- Undefined:
  - Popped bytes are consumed immediately.
  - The response is released at txact fall regardless of sent count.

## Test plan
- Write 10 samples 0x00..0x09, endpt=STREAM_EP, txact, 10 pops → txdat_len=10, txcork=0, bytes 0x00..0x09, txval falls after 10th pop, fifo_level=0.
- Fill 2^FIFO_AW+3 samples → fifo_level=512, ovf=1, first packet length 64 starting at byte 0; ovf_clr → ovf=0.
- Load response 0xA5,0x5A,0x3C (last on 3rd), endpt=RESP_EP → txdat_len=3, resp_ready=0 until sent, then 1.
- Empty FIFO, endpt=STREAM_EP, txact → txcork=1, txval=0; endpt=7 → txcork=1, txdat_len=0.
- 8 samples queued, txact, 3 pops, txact drops → with USB_TX_RETRY_EN the next packet is len 8 starting at byte 0; without it, len 5 starting at byte 3.
- rst during SEND after 2 pops → all outputs at reset values, fifo_level=0, resp_ready=1.

Source files
------------

// File: rtl/usb_tx_sched.sv
// IN-path transmit scheduler: stream FIFO plus single response buffer, sequenced onto txval/txcork/txdat/txpop.
// Optional USB_TX_RETRY_EN: stream pointer and response release commit only on a fully sent packet.
module usb_tx_sched #(
    parameter int unsigned FIFO_AW    = 9,
    parameter int unsigned MAX_PKT    = 64,
    parameter int unsigned STREAM_EP  = 1,
    parameter int unsigned RESP_EP    = 2,
    parameter int unsigned RESP_DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adc_valid,
    input  logic [7:0]         adc_data,
    input  logic               resp_valid,
    input  logic [7:0]         resp_data,
    input  logic               resp_last,
    output logic               resp_ready,
    input  logic               txact,
    input  logic [3:0]         endpt,
    input  logic               txpop,
    output logic               txval,
    output logic               txcork,
    output logic [7:0]         txdat,
    output logic [11:0]        txdat_len,
    output logic               ovf,
    input  logic               ovf_clr,
    output logic [FIFO_AW:0]   fifo_level
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned RCW   = $clog2(RESP_DEPTH + 1);
    localparam int unsigned RAW   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [FIFO_AW:0] FULL_LVL = DEPTH;
    localparam logic [FIFO_AW:0] PTR_ONE  = 1;
    localparam logic [RCW-1:0]   RCNT_ONE = 1;
    localparam logic [RCW-1:0]   RCNT_TOP = RESP_DEPTH - 1;
    localparam logic [11:0]      MAX_LEN  = MAX_PKT;
    localparam logic [3:0]       S_EP     = STREAM_EP;
    localparam logic [3:0]       R_EP     = RESP_EP;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [3:0]         ep_q, ep_d;
    logic [11:0]        sent_q, sent_d, len_q, len_d;
    logic               txval_q, txval_d, txcork_q, txcork_d;
    logic [7:0]         txdat_q, txdat_d;
    logic [FIFO_AW:0]   wr_q, wr_d, rd_q, rd_d, level_q, level_d;
    logic               ovf_q, ovf_d;
    logic [RCW-1:0]     rcnt_q, rcnt_d, rrd_q, rrd_d;
    logic               rheld_q, rheld_d, rready_q, rready_d;
    logic               tx_end, pop_ok, pop_stream, pop_resp;
    logic               free_evt, fifo_wr, drop, resp_wr, resp_release;
    logic [11:0]        lvl_ext;
`ifdef USB_TX_RETRY_EN
    logic [FIFO_AW:0]   cm_q, cm_d;
    logic               pkt_done;
`endif

    logic [7:0] fifo_mem_q [DEPTH];
    logic [7:0] resp_mem_q [RESP_DEPTH];

    always_comb begin
        state_d      = state_q;
        ep_d         = ep_q;
        len_d        = len_q;
        txval_d      = txval_q;
        txcork_d     = txcork_q;
        txdat_d      = txdat_q;
        rd_d         = rd_q;
        rcnt_d       = rcnt_q;
        rrd_d        = rrd_q;
        rheld_d      = rheld_q;
        resp_release = 1'b0;
        lvl_ext      = 12'(level_q);

        tx_end     = (state_q == SEND) && !txact;
        pop_ok     = (state_q == SEND) && txpop && (sent_q < len_q);
        pop_stream = pop_ok && (ep_q == S_EP);
        pop_resp   = pop_ok && (ep_q == R_EP);
        sent_d     = pop_ok ? sent_q + 12'd1 : sent_q;

        if (pop_stream)
            rd_d = rd_q + PTR_ONE;
`ifdef USB_TX_RETRY_EN
        // Speculative rd pointer; cm is what the FIFO considers consumed.
        cm_d     = cm_q;
        pkt_done = (sent_d == len_q);
        if (tx_end && ep_q == S_EP) begin
            if (pkt_done)
                cm_d = rd_d;
            else
                rd_d = cm_q;
        end
        free_evt = tx_end && (ep_q == S_EP) && pkt_done && (len_q != '0);
        level_d  = wr_q - cm_d;
`else
        free_evt = pop_stream;
        level_d  = wr_q - rd_d;
`endif
        fifo_wr = adc_valid && ((level_q != FULL_LVL) || free_evt);
        drop    = adc_valid && !fifo_wr;
        wr_d    = fifo_wr ? wr_q + PTR_ONE : wr_q;
        if (fifo_wr)
            level_d = level_d + PTR_ONE;
        ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

        resp_wr = resp_valid && rready_q;
        if (resp_wr) begin
            rcnt_d = rcnt_q + RCNT_ONE;
            if (resp_last || rcnt_q == RCNT_TOP)
                rheld_d = 1'b1;
        end
        if (pop_resp)
            rrd_d = rrd_q + RCNT_ONE;
        if (tx_end && ep_q == R_EP && rheld_q) begin
`ifdef USB_TX_RETRY_EN
            resp_release = pkt_done;
            rrd_d        = '0;
`else
            resp_release = 1'b1;
`endif
        end
        if (resp_release) begin
            rheld_d = 1'b0;
            rcnt_d  = '0;
            rrd_d   = '0;
        end
        rready_d = !rheld_d;

        case (state_q)
            IDLE: begin
                txval_d = 1'b0;
                if (txact) begin
                    state_d = SEND;
                    txval_d = (len_q != '0);
                end else begin
                    ep_d = endpt;
                    if (endpt == S_EP) begin
                        len_d    = (lvl_ext > MAX_LEN) ? MAX_LEN : lvl_ext;
                        txcork_d = (len_d == '0);
                        txdat_d  = fifo_mem_q[rd_d[FIFO_AW-1:0]];
                    end else if (endpt == R_EP) begin
                        len_d    = rheld_q ? 12'(rcnt_q) : '0;
                        txcork_d = !rheld_q;
                        txdat_d  = resp_mem_q[0];
                    end else begin
                        len_d    = '0;
                        txcork_d = 1'b1;
                        txdat_d  = '0;
                    end
                end
            end
            SEND: begin
                txval_d = (sent_d < len_q);
                if (ep_q == S_EP)
                    txdat_d = fifo_mem_q[rd_d[FIFO_AW-1:0]];
                else if (ep_q == R_EP)
                    txdat_d = resp_mem_q[rrd_d[RAW-1:0]];
                if (!txact) begin
                    state_d = IDLE;
                    txval_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ep_q     <= '0;
            sent_q   <= '0;
            len_q    <= '0;
            txval_q  <= 1'b0;
            txcork_q <= 1'b1;
            txdat_q  <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            rcnt_q   <= '0;
            rrd_q    <= '0;
            rheld_q  <= 1'b0;
            rready_q <= 1'b1;
`ifdef USB_TX_RETRY_EN
            cm_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ep_q     <= ep_d;
            sent_q   <= (state_q == IDLE) ? 12'd0 : sent_d;
            len_q    <= len_d;
            txval_q  <= txval_d;
            txcork_q <= txcork_d;
            txdat_q  <= txdat_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            rcnt_q   <= rcnt_d;
            rrd_q    <= rrd_d;
            rheld_q  <= rheld_d;
            rready_q <= rready_d;
`ifdef USB_TX_RETRY_EN
            cm_q     <= cm_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr)
            fifo_mem_q[wr_q[FIFO_AW-1:0]] <= adc_data;
        if (resp_wr)
            resp_mem_q[rcnt_q[RAW-1:0]] <= resp_data;
    end

    assign txval      = txval_q;
    assign txcork     = txcork_q;
    assign txdat      = txdat_q;
    assign txdat_len  = len_q;
    assign ovf        = ovf_q;
    assign fifo_level = level_q;
    assign resp_ready = rready_q;
endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed self-checking bench for usb_tx_sched (default parameters).
module tb_usb_tx_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adc_valid = 1'b0;
    logic [7:0]  adc_data = '0;
    logic        resp_valid = 1'b0;
    logic [7:0]  resp_data = '0;
    logic        resp_last = 1'b0;
    logic        resp_ready;
    logic        txact = 1'b0;
    logic [3:0]  endpt = '0;
    logic        txpop = 1'b0;
    logic        txval, txcork;
    logic [7:0]  txdat;
    logic [11:0] txdat_len;
    logic        ovf;
    logic        ovf_clr = 1'b0;
    logic [9:0]  fifo_level;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    usb_tx_sched #(.FIFO_AW(9), .MAX_PKT(64), .STREAM_EP(1), .RESP_EP(2), .RESP_DEPTH(64)) dut (
        .clk(clk), .rst(rst),
        .adc_valid(adc_valid), .adc_data(adc_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
        .resp_ready(resp_ready),
        .txact(txact), .endpt(endpt), .txpop(txpop),
        .txval(txval), .txcork(txcork), .txdat(txdat), .txdat_len(txdat_len),
        .ovf(ovf), .ovf_clr(ovf_clr), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_adc(input int unsigned n, input logic [7:0] base);
        for (int unsigned k = 0; k < n; k++) begin
            adc_valid = 1'b1;
            adc_data  = base + 8'(k);
            tick(1);
        end
        adc_valid = 1'b0;
    endtask

    task automatic pop();
        txpop = 1'b1;
        tick(1);
        txpop = 1'b0;
        tick(1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_txval"}, 32'(txval), 32'd0);
        check({pfx, "_txcork"}, 32'(txcork), 32'd1);
        check({pfx, "_txdat"}, 32'(txdat), 32'd0);
        check({pfx, "_len"}, 32'(txdat_len), 32'd0);
        check({pfx, "_rready"}, 32'(resp_ready), 32'd1);
        check({pfx, "_ovf"}, 32'(ovf), 32'd0);
        check({pfx, "_level"}, 32'(fifo_level), 32'd0);
    endtask

    initial begin
        #1;
        tick(2);
        rst = 1'b0;
        check_reset_vals("rst");

        // Basic stream packet of 10 bytes
        push_adc(10, 8'h00);
        check("s10_level", 32'(fifo_level), 32'd10);
        endpt = 4'd1;
        tick(2);
        check("s10_len", 32'(txdat_len), 32'd10);
        check("s10_cork", 32'(txcork), 32'd0);
        check("s10_head", 32'(txdat), 32'h00);
        txact = 1'b1;
        tick(1);
        check("s10_txval", 32'(txval), 32'd1);
        for (int i = 0; i < 10; i++) begin
            pop();
            if (i < 9) begin
                check("s10_byte", 32'(txdat), 32'(i + 1));
                check("s10_val", 32'(txval), 32'd1);
            end else begin
                check("s10_valend", 32'(txval), 32'd0);
            end
        end
        txact = 1'b0;
        tick(2);
        check("s10_level0", 32'(fifo_level), 32'd0);

        // Empty FIFO NAKs; extra pops ignored; unknown endpoint
        tick(1);
        check("emp_cork", 32'(txcork), 32'd1);
        check("emp_len", 32'(txdat_len), 32'd0);
        txact = 1'b1;
        tick(1);
        check("emp_txval", 32'(txval), 32'd0);
        pop();
        check("emp_popval", 32'(txval), 32'd0);
        check("emp_poplvl", 32'(fifo_level), 32'd0);
        txact = 1'b0;
        endpt = 4'd7;
        tick(3);
        check("ep7_cork", 32'(txcork), 32'd1);
        check("ep7_len", 32'(txdat_len), 32'd0);

        // Response message
        check("rsp_ready0", 32'(resp_ready), 32'd1);
        resp_valid = 1'b1; resp_data = 8'hA5; tick(1);
        resp_data = 8'h5A; tick(1);
        resp_data = 8'h3C; resp_last = 1'b1; tick(1);
        resp_valid = 1'b0; resp_last = 1'b0;
        check("rsp_ready_held", 32'(resp_ready), 32'd0);
        endpt = 4'd2;
        tick(2);
        check("rsp_len", 32'(txdat_len), 32'd3);
        check("rsp_cork", 32'(txcork), 32'd0);
        check("rsp_b0", 32'(txdat), 32'hA5);
        txact = 1'b1;
        tick(1);
        check("rsp_txval", 32'(txval), 32'd1);
        pop();
        check("rsp_b1", 32'(txdat), 32'h5A);
        pop();
        check("rsp_b2", 32'(txdat), 32'h3C);
        check("rsp_ready_send", 32'(resp_ready), 32'd0);
        pop();
        check("rsp_valend", 32'(txval), 32'd0);
        txact = 1'b0;
        tick(1);
        check("rsp_ready_rel", 32'(resp_ready), 32'd1);
        tick(2);
        check("rsp_cork_after", 32'(txcork), 32'd1);
        check("rsp_len_after", 32'(txdat_len), 32'd0);

        // Partial send then abort: retry rewinds, otherwise bytes consumed
        endpt = 4'd0;
        tick(1);
        push_adc(8, 8'h10);
        endpt = 4'd1;
        tick(2);
        check("rt_len0", 32'(txdat_len), 32'd8);
        check("rt_head0", 32'(txdat), 32'h10);
        txact = 1'b1;
        tick(1);
        pop(); pop(); pop();
        check("rt_b3", 32'(txdat), 32'h13);
        txact = 1'b0;
        tick(3);
`ifdef USB_TX_RETRY_EN
        check("rt_len1", 32'(txdat_len), 32'd8);
        check("rt_head1", 32'(txdat), 32'h10);
        check("rt_level", 32'(fifo_level), 32'd8);
`else
        check("rt_len1", 32'(txdat_len), 32'd5);
        check("rt_head1", 32'(txdat), 32'h13);
        check("rt_level", 32'(fifo_level), 32'd5);
`endif

        // Overflow: 515 writes into 512 entries
        endpt = 4'd0;
        pulse_rst();
        check("ovf_pre_level", 32'(fifo_level), 32'd0);
        for (int i = 0; i < 515; i++) begin
            adc_valid = 1'b1;
            adc_data  = 8'(i);
            tick(1);
        end
        adc_valid = 1'b0;
        check("ovf_level", 32'(fifo_level), 32'd512);
        check("ovf_set", 32'(ovf), 32'd1);
        endpt = 4'd1;
        tick(2);
        check("ovf_len", 32'(txdat_len), 32'd64);
        check("ovf_head", 32'(txdat), 32'h00);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'd0);
        adc_valid = 1'b1; ovf_clr = 1'b1; adc_data = 8'hEE; tick(1);
        adc_valid = 1'b0; ovf_clr = 1'b0;
        check("ovf_drop_wins", 32'(ovf), 32'd1);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        txact = 1'b1;
        tick(1);
        txpop = 1'b1; adc_valid = 1'b1; adc_data = 8'hEE; tick(1);
        txpop = 1'b0; adc_valid = 1'b0;
        check("full_pop_byte", 32'(txdat), 32'h01);
        check("full_pop_level", 32'(fifo_level), 32'd512);
`ifdef USB_TX_RETRY_EN
        check("full_pop_ovf", 32'(ovf), 32'd1);
`else
        check("full_pop_ovf", 32'(ovf), 32'd0);
`endif
        txact = 1'b0;
        tick(2);

        // Reset in the middle of a packet
        pulse_rst();
        endpt = 4'd0;
        push_adc(8, 8'h40);
        resp_valid = 1'b1; resp_data = 8'h77; resp_last = 1'b1; tick(1);
        resp_valid = 1'b0; resp_last = 1'b0;
        check("mr_ready_held", 32'(resp_ready), 32'd0);
        endpt = 4'd1;
        tick(2);
        txact = 1'b1;
        tick(1);
        pop(); pop();
        check("mr_b2", 32'(txdat), 32'h42);
        rst = 1'b1; txact = 1'b0;
        tick(1);
        rst = 1'b0;
        check_reset_vals("mr");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
